fifo_read_streamer: RTL and testbench
=====================================

# fifo_read_streamer

Read-side consumer for the team's async FIFO, living entirely in the read clock domain. It issues FIFO read enables, captures the read data that returns one cycle later, and presents it as a registered valid/ready stream to downstream logic. It sustains one word per cycle under continuous ready and never over-reads past the FIFO's empty flag.

## Interface
- WIDTH, 32, data word width; must match the FIFO WIDTH.
- SKID_DEPTH, 3, internal buffer entries; minimum 3, which is required for full throughput.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- clk  in  1  read-domain clock; the FIFO read clock.
- rstn  in  1  reset, asynchronous assert, active-low; one clock domain only.
- fifo_empty  in  1  FIFO empty flag, already synchronous to clk.
- fifo_rd_en  out  1  FIFO read enable.
- fifo_rd_data  in  WIDTH  FIFO read data; valid the cycle after a read is accepted.
- flush  in  1  synchronous discard of buffered and in-flight words.
- out_valid  out  1  head word available.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  head word.
- buf_level  out  $clog2(SKID_DEPTH+1)  words currently buffered.
- word_count  out  CNT_WIDTH  total words delivered since reset.

## Operation
- State consists of:
  - a circular buffer of SKID_DEPTH entries with head/tail pointers and count;
  - a `pending` flag, set the cycle after a read was issued;
  - `word_count`.
- Read issue: fifo_rd_en = !fifo_empty && !flush && (count + pending) < SKID_DEPTH.
  - Computed from registered state only, so there is no combinational path from out_ready to fifo_rd_en.
- Capture: when pending=1 and flush=0, fifo_rd_data is written at the tail. Tail advances modulo SKID_DEPTH.
- Output:
  - out_valid = (count != 0).
  - out_data = entry at head.
  - pop = out_valid && out_ready, which advances head modulo SKID_DEPTH.
- Count update: count_next = count + (pending && !flush) - pop. The combination of push and pop in the same cycle leaves count unchanged.
- word_count increments by 1 on every pop and wraps from 2^CNT_WIDTH-1 to 0. It is not cleared by flush.
- flush:
  - count, head, tail → 0 next cycle;
  - a word arriving in the flush cycle is dropped;
  - fifo_rd_en is held 0 during flush;
  - any pop in the flush cycle still completes and still counts.
- Invariant: count + pending ≤ SKID_DEPTH at all times. Overflow of the buffer is impossible by construction.
- Invariant: fifo_rd_en is never 1 while fifo_empty = 1.
- buf_level = count.

## Timing
- Reset values (async, rstn=0): fifo_rd_en=0, pending=0, count=0, head=tail=0, out_valid=0, out_data=0, buf_level=0, word_count=0.
- Reset mid-operation discards all buffered and in-flight data immediately.
- First read may issue in the first clk edge after rstn deasserts.
- Latency with an idle, empty buffer:
  - fifo_rd_en high at cycle N;
  - data captured at the edge ending cycle N+1;
  - out_valid high in cycle N+2.
- Steady-state throughput is one word per cycle when fifo_empty=0 and out_ready=1 continuously.
- Backpressure (out_ready=0): reads continue until count+pending = SKID_DEPTH, then fifo_rd_en drops. Exactly SKID_DEPTH words end up held.
- When the FIFO goes empty, fifo_rd_en drops in the same cycle because it is combinational from fifo_empty. Already-pending data is still captured.
- out_data and out_valid hold stable while out_valid=1 and out_ready=0.

## Test plan
- Reset/idle: hold rstn=0 with fifo_empty=0. Then all outputs are 0 and fifo_rd_en=0. Release rstn: fifo_rd_en goes to 1 on the next cycle.
- Streaming: preload the FIFO model with 0x00000001..0x00000010 and hold out_ready=1.
  - out_valid is high for 16 consecutive cycles starting 2 cycles after the first read.
  - Data appears in order.
  - word_count ends at 16.
- Backpressure: feed 8 words with out_ready=0.
  - Exactly 3 reads issue.
  - buf_level settles at 3 and fifo_rd_en stays 0.
  - Raise out_ready: the remaining 5 words drain in order with no gaps after refill.
- Empty boundary: the FIFO holds 1 word.
  - One read issues, then fifo_rd_en stays 0 while fifo_empty=1.
  - out_valid pulses for one beat, and no read is issued while empty.
- Flush mid-flight: assert flush for one cycle while buf_level=2 and pending=1.
  - Next cycle: buf_level=0 and out_valid=0.
  - The dropped in-flight word never appears.
  - word_count is unchanged apart from the pop in the flush cycle.
- Counter wrap: run with CNT_WIDTH=4 and 17 pops. word_count sequence ends …15, 0, 1.

Source files
------------

// File: rtl/fifo_read_streamer.sv
// Read-side consumer for the async FIFO: issues read enables, captures the
// one-cycle-late read data into a small circular buffer and streams it out.
module fifo_read_streamer #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SKID_DEPTH = 3,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              fifo_empty,
    output logic                              fifo_rd_en,
    input  logic [WIDTH-1:0]                  fifo_rd_data,
    input  logic                              flush,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH-1:0]                  out_data,
    output logic [$clog2(SKID_DEPTH+1)-1:0]   buf_level,
    output logic [CNT_WIDTH-1:0]              word_count
);

    localparam int unsigned   LW       = $clog2(SKID_DEPTH + 1);
    localparam int unsigned   PW       = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(SKID_DEPTH - 1);
    localparam logic [LW:0]   DEPTH_W  = (LW + 1)'(SKID_DEPTH);

    logic [WIDTH-1:0]     r_mem [SKID_DEPTH];
    logic [PW-1:0]        r_head;
    logic [PW-1:0]        r_tail;
    logic [LW-1:0]        r_count;
    logic                 r_pending;
    logic [CNT_WIDTH-1:0] r_word_count;

    logic                 w_rd_en;
    logic                 w_push;
    logic                 w_pop;
    logic [LW:0]          w_committed;
    logic [PW-1:0]        w_head_inc;
    logic [PW-1:0]        w_tail_inc;
    logic [LW-1:0]        w_count_next;

    // Slots already claimed: buffered words plus the word still in flight.
    // Read issue depends only on registered state, never on out_ready.
    always_comb begin
        w_committed = {1'b0, r_count} + (LW + 1)'(r_pending);
        w_rd_en     = rstn && !fifo_empty && !flush && (w_committed < DEPTH_W);
        w_push      = r_pending && !flush;
        w_pop       = (r_count != '0) && out_ready;
        w_head_inc  = (r_head == LAST_IDX) ? '0 : r_head + PW'(1);
        w_tail_inc  = (r_tail == LAST_IDX) ? '0 : r_tail + PW'(1);
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + LW'(1);
            2'b01:   w_count_next = r_count - LW'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pending    <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_pending <= w_rd_en;
            if (w_pop) begin
                r_word_count <= r_word_count + CNT_WIDTH'(1);
            end
        end
    end

    // A pop in the flush cycle still counts above; buffer state is discarded here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= fifo_rd_data;
                r_tail        <= w_tail_inc;
            end
            if (w_pop) begin
                r_head <= w_head_inc;
            end
            r_count <= w_count_next;
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign out_valid  = (r_count != '0);
    assign out_data   = r_mem[r_head];
    assign buf_level  = r_count;
    assign word_count = r_word_count;

    a_no_overread: assert property (@(posedge clk) disable iff (!rstn)
        !(fifo_rd_en && fifo_empty));

    a_bounded: assert property (@(posedge clk) disable iff (!rstn)
        w_committed <= DEPTH_W);

    a_hold_stable: assert property (@(posedge clk) disable iff (!rstn)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Scoreboard bench for fifo_read_streamer: a behavioural FIFO feeds the DUT,
// expected words are queued at load time and checked by a negedge monitor.
module tb_fifo_read_streamer;

    localparam int unsigned W = 32;

    logic          clk          = 1'b0;
    logic          rstn         = 1'b0;
    logic          fifo_empty   = 1'b1;
    logic [W-1:0]  fifo_rd_data = '0;
    logic          flush        = 1'b0;
    logic          out_ready    = 1'b0;

    logic          fifo_rd_en;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [1:0]    buf_level;
    logic [15:0]   word_count;

    logic          wr_rd_en;
    logic          wr_valid;
    logic [W-1:0]  wr_data;
    logic [1:0]    wr_level;
    logic [3:0]    wr_count;

    logic [W-1:0]  fifo_q [$];
    logic [W-1:0]  exp_q  [$];
    int unsigned   n_vec      = 0;
    int unsigned   n_err      = 0;
    int unsigned   n_reads    = 0;
    int unsigned   n_overread = 0;

    always #5 clk = ~clk;

    fifo_read_streamer #(.WIDTH(W), .SKID_DEPTH(3), .CNT_WIDTH(16)) dut (
        .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_rd_data(fifo_rd_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .buf_level(buf_level),
        .word_count(word_count)
    );

    // Same stimulus, narrow counter, to observe wrap-around.
    fifo_read_streamer #(.WIDTH(W), .SKID_DEPTH(3), .CNT_WIDTH(4)) dut_wrap (
        .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_rd_en(wr_rd_en),
        .fifo_rd_data(fifo_rd_data), .flush(flush), .out_valid(wr_valid),
        .out_ready(out_ready), .out_data(wr_data), .buf_level(wr_level),
        .word_count(wr_count)
    );

    // FIFO model: data returns the cycle after an accepted read.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            n_reads <= n_reads + 1;
            if (fifo_q.size() == 0) n_overread <= n_overread + 1;
            else fifo_rd_data <= fifo_q.pop_front();
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pop-and-compare on every accepted beat, plus hold stability.
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_data = '0;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_word: got 0x%08h, expected no word", out_data);
                end else begin
                    check("stream_data", out_data, exp_q.pop_front());
                end
            end
            prev_hold = out_valid && !out_ready && !flush;
            prev_data = out_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Samples out_valid now and after each of the next cycles; reports the
    // first sample index where it was high and the length of that run.
    task automatic measure_valid(input int cycles, output int first, output int run);
        bit gap;
        first = -1;
        run   = 0;
        gap   = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (out_valid) begin
                if (first < 0) first = i;
                if (!gap) run++;
            end else if (first >= 0) begin
                gap = 1'b1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [W-1:0] base, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + W'(i));
    endtask

    initial begin
        int first;
        int run;
        int unsigned reads0;
        logic [15:0] wc0;
        logic [3:0] seq [$];

        // Reset / idle with a non-empty FIFO
        load(32'h1, 16);
        for (int i = 1; i <= 16; i++) exp_q.push_back(32'(i));
        tick(3);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_level", 32'(buf_level), 32'd0);
        check("rst_wcount", 32'(word_count), 32'd0);
        rstn      = 1'b1;
        out_ready = 1'b1;
        #1;
        check("first_rd_en", 32'(fifo_rd_en), 32'd1);

        // Streaming 16 words under continuous ready
        measure_valid(22, first, run);
        check("stream_first_valid", 32'(first), 32'd2);
        check("stream_run", 32'(run), 32'd16);
        check("stream_wcount", 32'(word_count), 32'd16);
        check("stream_reads", n_reads, 32'd16);
        check("stream_rd_en_idle", 32'(fifo_rd_en), 32'd0);

        // Backpressure: 8 words, ready low
        out_ready = 1'b0;
        reads0 = n_reads;
        load(32'h100, 8);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h100 + 32'(i));
        tick(10);
        check("bp_reads", n_reads - reads0, 32'd3);
        check("bp_level", 32'(buf_level), 32'd3);
        check("bp_rd_en", 32'(fifo_rd_en), 32'd0);
        check("bp_head", out_data, 32'h100);
        tick(2);
        check("bp_level_hold", 32'(buf_level), 32'd3);
        out_ready = 1'b1;
        #1;
        measure_valid(14, first, run);
        check("drain_first", 32'(first), 32'd0);
        check("drain_run", 32'(run), 32'd8);
        check("drain_reads", n_reads - reads0, 32'd8);
        check("drain_wcount", 32'(word_count), 32'd24);

        // Empty boundary: a single word
        reads0 = n_reads;
        fifo_q.push_back(32'h200);
        exp_q.push_back(32'h200);
        measure_valid(10, first, run);
        check("one_first", 32'(first), 32'd3);
        check("one_run", 32'(run), 32'd1);
        check("one_reads", n_reads - reads0, 32'd1);
        check("one_rd_en", 32'(fifo_rd_en), 32'd0);
        check("one_wcount", 32'(word_count), 32'd25);

        // Flush with two buffered words and one in flight
        out_ready = 1'b0;
        reads0 = n_reads;
        load(32'h300, 5);
        exp_q.push_back(32'h300);
        exp_q.push_back(32'h303);
        exp_q.push_back(32'h304);
        tick(4);
        check("fl_pre_level", 32'(buf_level), 32'd2);
        check("fl_pre_reads", n_reads - reads0, 32'd3);
        wc0 = word_count;
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("fl_rd_en", 32'(fifo_rd_en), 32'd0);
        tick(1);
        flush = 1'b0;
        check("fl_level", 32'(buf_level), 32'd0);
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_wcount", 32'(word_count), 32'(wc0) + 32'd1);
        tick(10);
        check("fl_post_wcount", 32'(word_count), 32'(wc0) + 32'd3);
        check("fl_post_level", 32'(buf_level), 32'd0);

        // Counter wrap with a 4-bit counter, 17 pops
        rstn = 1'b0;
        #1;
        check("wrap_rst_wcount", 32'(word_count), 32'd0);
        check("wrap_rst_wr", 32'(wr_count), 32'd0);
        load(32'h400, 17);
        for (int i = 0; i < 17; i++) exp_q.push_back(32'h400 + 32'(i));
        tick(2);
        rstn = 1'b1;
        seq.push_back(wr_count);
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (wr_count != seq[seq.size()-1]) seq.push_back(wr_count);
        end
        check("wrap_len", 32'(seq.size()), 32'd18);
        if (seq.size() >= 3) begin
            check("wrap_m2", 32'(seq[seq.size()-3]), 32'd15);
            check("wrap_m1", 32'(seq[seq.size()-2]), 32'd0);
            check("wrap_end", 32'(seq[seq.size()-1]), 32'd1);
        end
        check("wrap_main", 32'(word_count), 32'd17);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("no_overread", n_overread, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
